// File: rtl/mips_sequencer.sv
// Multi-cycle FETCH/EXEC1/EXEC2/HALT sequencer for the MIPS core: owns the instruction and
// load-data registers, counts retired instructions and bus stalls, and halts on a hung bus.
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | instruction read in flight (unless halt), instr captured on exit
// EXEC1 | first execute cycle, data access for loads/stores
// EXEC2 | second execute cycle for instructions that need it
// HALT  | absorbing; only reset leaves it
module mips_sequencer #(
    parameter int COUNT_W  = 32,
    parameter int MAX_WAIT = 0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               waitrequest_i,
    input  logic [31:0]        readdata_i,
    input  logic               halt_i,
    input  logic               extra_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    output logic [1:0]         state_o,
    output logic [31:0]        instr_o,
    output logic [31:0]        load_data_o,
    output logic               fetch_read_o,
    output logic               retire_o,
    output logic               active_o,
    output logic               timeout_o,
    output logic [COUNT_W-1:0] instr_count_o,
    output logic [COUNT_W-1:0] stall_count_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC1 = 2'b01,
        S_EXEC2 = 2'b10,
        S_HALT  = 2'b11
    } state_e;

    localparam int WCNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = (MAX_WAIT > 0) ? WCNT_W'(MAX_WAIT - 1) : '0;

    state_e             state_q;
    logic [31:0]        instr_q;
    logic [31:0]        load_data_q;
    logic               retire_q;
    logic               timeout_q;
    logic [COUNT_W-1:0] instr_count_q;
    logic [COUNT_W-1:0] instr_count_d;
    logic [COUNT_W-1:0] stall_count_q;
    logic [COUNT_W-1:0] stall_count_d;
    logic [WCNT_W-1:0]  wcnt_q;
    logic [WCNT_W-1:0]  wcnt_d;

    logic mem_pending;
    logic stalled;
    logic expire;
    logic retire_edge;

    assign mem_pending = ((state_q == S_FETCH) && !halt_i) ||
                         ((state_q == S_EXEC1) && (mem_read_i || mem_write_i));
    assign stalled     = mem_pending && waitrequest_i;

    // A stalled edge that would make the run MAX_WAIT long halts instead of waiting again.
    assign expire      = (MAX_WAIT > 0) && stalled && (wcnt_q == WCNT_LAST);

    assign retire_edge = (state_q == S_EXEC2) ||
                         ((state_q == S_EXEC1) && !stalled && !extra_i);

    assign wcnt_d        = ((MAX_WAIT == 0) || !stalled) ? '0 : wcnt_q + WCNT_W'(1);
    assign instr_count_d = retire_edge ? instr_count_q + COUNT_W'(1) : instr_count_q;
    assign stall_count_d = stalled ? stall_count_q + COUNT_W'(1) : stall_count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_FETCH;
            instr_q       <= '0;
            load_data_q   <= '0;
            retire_q      <= 1'b0;
            timeout_q     <= 1'b0;
            instr_count_q <= '0;
            stall_count_q <= '0;
            wcnt_q        <= '0;
        end else begin
            retire_q      <= retire_edge;
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
            wcnt_q        <= wcnt_d;
            case (state_q)
                S_FETCH: begin
                    if (halt_i) begin
                        state_q <= S_HALT;
                    end else if (expire) begin
                        state_q   <= S_HALT;
                        timeout_q <= 1'b1;
                    end else if (!waitrequest_i) begin
                        instr_q <= readdata_i;
                        state_q <= S_EXEC1;
                    end
                end
                S_EXEC1: begin
                    if (expire) begin
                        state_q   <= S_HALT;
                        timeout_q <= 1'b1;
                    end else if (!stalled) begin
                        if (mem_read_i) begin
                            load_data_q <= readdata_i;
                        end
                        state_q <= extra_i ? S_EXEC2 : S_FETCH;
                    end
                end
                S_EXEC2: begin
                    state_q <= S_FETCH;
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    assign state_o       = state_q;
    assign instr_o       = instr_q;
    assign load_data_o   = load_data_q;
    assign retire_o      = retire_q;
    assign timeout_o     = timeout_q;
    assign instr_count_o = instr_count_q;
    assign stall_count_o = stall_count_q;
    assign fetch_read_o  = (state_q == S_FETCH) && !halt_i;
    assign active_o      = (state_q != S_HALT);

endmodule

// File: tb/tb_mips_sequencer.sv
// Bench for mips_sequencer: two instances (watchdog off / MAX_WAIT=4) share one stimulus stream.
module tb_mips_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr;
    logic [31:0] rd;
    logic        hlt, ext, mrd, mwr;

    logic [1:0]  st0, st4;
    logic [31:0] ins0, ins4, ld0, ld4, ic0, ic4, sc0, sc4;
    logic        fr0, fr4, ret0, ret4, act0, act4, to0, to4;

    always #5 clk = ~clk;

    mips_sequencer #(.COUNT_W(32), .MAX_WAIT(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .waitrequest_i(wr), .readdata_i(rd),
        .halt_i(hlt), .extra_i(ext), .mem_read_i(mrd), .mem_write_i(mwr),
        .state_o(st0), .instr_o(ins0), .load_data_o(ld0), .fetch_read_o(fr0),
        .retire_o(ret0), .active_o(act0), .timeout_o(to0),
        .instr_count_o(ic0), .stall_count_o(sc0)
    );

    mips_sequencer #(.COUNT_W(32), .MAX_WAIT(4)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .waitrequest_i(wr), .readdata_i(rd),
        .halt_i(hlt), .extra_i(ext), .mem_read_i(mrd), .mem_write_i(mwr),
        .state_o(st4), .instr_o(ins4), .load_data_o(ld4), .fetch_read_o(fr4),
        .retire_o(ret4), .active_o(act4), .timeout_o(to4),
        .instr_count_o(ic4), .stall_count_o(sc4)
    );

    localparam logic [31:0] I_ADDIU = 32'h24020005;
    localparam logic [31:0] I_LW    = 32'h8C430000;
    localparam logic [31:0] I_SW    = 32'hAC440004;
    localparam logic [31:0] D_BEEF  = 32'hDEADBEEF;

    typedef struct {
        logic        wr;
        logic [31:0] rd;
        logic        h, e, r, w;
        logic [1:0]  st;
        logic        rt;
        logic [31:0] ic, sc, ins, ld;
    } vec_t;

    vec_t        vecs[$];
    vec_t        v;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  exp_cur;
    logic [31:0] m_ic, m_sc, m_ins, m_ld, dat;
    int          fw, ew, kind;
    logic        re, rr, rw;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic w_r, input logic [31:0] d, input logic h, e, r, w,
                                input logic [1:0] st, input logic rt,
                                input logic [31:0] ic, sc, ins, ld);
        vec_t t;
        t.wr = w_r; t.rd = d; t.h = h; t.e = e; t.r = r; t.w = w;
        t.st = st; t.rt = rt; t.ic = ic; t.sc = sc; t.ins = ins; t.ld = ld;
        return t;
    endfunction

    task automatic drive(input logic w_r, input logic [31:0] d, input logic h, e, r, w);
        wr = w_r; rd = d; hlt = h; ext = e; mrd = r; mwr = w;
    endtask

    // One clock: combinational outputs checked before the edge, registered ones #1 after it.
    task automatic cyc(input string tag, input logic w_r, input logic [31:0] d,
                       input logic h, e, r, w, input logic [1:0] st, input logic rt);
        drive(w_r, d, h, e, r, w);
        #1;
        chk({tag, " fetch_read0"}, fr0, (exp_cur == 2'b00) && !h);
        chk({tag, " fetch_read4"}, fr4, (exp_cur == 2'b00) && !h);
        chk({tag, " active0"}, act0, exp_cur != 2'b11);
        @(posedge clk);
        #1;
        chk({tag, " state0"}, st0, st);
        chk({tag, " state4"}, st4, st);
        chk({tag, " retire0"}, ret0, rt);
        chk({tag, " retire4"}, ret4, rt);
        exp_cur = st;
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] ic, sc, ins, ld);
        chk({tag, " instr_count0"}, ic0, ic);
        chk({tag, " instr_count4"}, ic4, ic);
        chk({tag, " stall_count0"}, sc0, sc);
        chk({tag, " stall_count4"}, sc4, sc);
        chk({tag, " instr0"}, ins0, ins);
        chk({tag, " instr4"}, ins4, ins);
        chk({tag, " load_data0"}, ld0, ld);
        chk({tag, " load_data4"}, ld4, ld);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " state0"}, st0, 2'b00);
        chk({tag, " state4"}, st4, 2'b00);
        chk_regs(tag, 0, 0, 0, 0);
        chk({tag, " retire0"}, ret0, 1'b0);
        chk({tag, " retire4"}, ret4, 1'b0);
        chk({tag, " active0"}, act0, 1'b1);
        chk({tag, " active4"}, act4, 1'b1);
        chk({tag, " timeout0"}, to0, 1'b0);
        chk({tag, " timeout4"}, to4, 1'b0);
        chk({tag, " fetch_read0"}, fr0, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk_reset_vals(tag);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cur = 2'b00;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        // wr, rd, h, e, r, w | state, retire, instr_count, stall_count, instr, load_data
        vecs.push_back(mk(0, I_ADDIU, 0, 0, 0, 0, 2'b01, 0, 0, 0, I_ADDIU, 0));
        vecs.push_back(mk(0, I_ADDIU, 0, 0, 0, 0, 2'b00, 1, 1, 0, I_ADDIU, 0));
        vecs.push_back(mk(0, I_ADDIU, 0, 0, 0, 0, 2'b01, 0, 1, 0, I_ADDIU, 0));
        vecs.push_back(mk(0, I_ADDIU, 0, 0, 0, 0, 2'b00, 1, 2, 0, I_ADDIU, 0));
        vecs.push_back(mk(0, I_ADDIU, 0, 0, 0, 0, 2'b01, 0, 2, 0, I_ADDIU, 0));
        vecs.push_back(mk(0, I_ADDIU, 0, 0, 0, 0, 2'b00, 1, 3, 0, I_ADDIU, 0));
        vecs.push_back(mk(0, I_LW,    0, 1, 1, 0, 2'b01, 0, 3, 0, I_LW, 0));
        vecs.push_back(mk(1, D_BEEF,  0, 1, 1, 0, 2'b01, 0, 3, 1, I_LW, 0));
        vecs.push_back(mk(1, D_BEEF,  0, 1, 1, 0, 2'b01, 0, 3, 2, I_LW, 0));
        vecs.push_back(mk(0, D_BEEF,  0, 1, 1, 0, 2'b10, 0, 3, 2, I_LW, D_BEEF));
        vecs.push_back(mk(0, 32'h0,   0, 1, 1, 0, 2'b00, 1, 4, 2, I_LW, D_BEEF));
        vecs.push_back(mk(1, 32'h0,   0, 0, 0, 0, 2'b00, 0, 4, 3, I_LW, D_BEEF));
        vecs.push_back(mk(0, I_SW,    0, 0, 0, 1, 2'b01, 0, 4, 3, I_SW, D_BEEF));
        vecs.push_back(mk(1, 32'h12345678, 0, 0, 0, 1, 2'b01, 0, 4, 4, I_SW, D_BEEF));
        vecs.push_back(mk(0, 32'h12345678, 0, 0, 0, 1, 2'b00, 1, 5, 4, I_SW, D_BEEF));
        vecs.push_back(mk(0, 32'h0,   0, 0, 0, 0, 2'b01, 0, 5, 4, 32'h0, D_BEEF));
        vecs.push_back(mk(1, 32'hFFFFFFFF, 0, 0, 0, 0, 2'b00, 1, 6, 4, 32'h0, D_BEEF));

        do_reset("reset");
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cyc($sformatf("vec%0d", i), v.wr, v.rd, v.h, v.e, v.r, v.w, v.st, v.rt);
            chk_regs($sformatf("vec%0d", i), v.ic, v.sc, v.ins, v.ld);
        end

        // halt beats waitrequest in FETCH; HALT then freezes everything
        cyc("halt_enter", 1'b1, 32'h55555555, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        chk("halt active0", act0, 1'b0);
        chk("halt active4", act4, 1'b0);
        chk("halt timeout4", to4, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc("halt_hold", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'b11, 1'b0);
            chk_regs("halt_hold", 6, 4, 32'h0, D_BEEF);
            chk("halt_hold timeout4", to4, 1'b0);
        end

        // watchdog: waitrequest stuck high in FETCH
        do_reset("reset_wd");
        for (int k = 0; k < 3; k++) cyc("wd_stall", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        chk("wd_fire state4", st4, 2'b11);
        chk("wd_fire timeout4", to4, 1'b1);
        chk("wd_fire stall_count4", sc4, 4);
        chk("wd_fire active4", act4, 1'b0);
        chk("wd_off state0", st0, 2'b00);
        chk("wd_off timeout0", to0, 1'b0);
        chk("wd_off stall_count0", sc0, 4);
        repeat (5) @(posedge clk);
        #1;
        chk("wd_frozen state4", st4, 2'b11);
        chk("wd_frozen stall_count4", sc4, 4);
        chk("wd_frozen timeout4", to4, 1'b1);
        chk("wd_off_later stall_count0", sc0, 9);
        chk("wd_off_later timeout0", to0, 1'b0);

        // waitrequest drops on the deciding edge; the watchdog count then restarts
        do_reset("reset_wd2");
        for (int k = 0; k < 3; k++) cyc("wd2_fstall", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc("wd2_fetch", 1'b0, I_LW, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
        chk("wd2_fetch timeout4", to4, 1'b0);
        for (int k = 0; k < 3; k++) cyc("wd2_estall", 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
        cyc("wd2_exec", 1'b0, 32'h5555AAAA, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++) cyc("wd2_fstall2", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc("wd2_fetch2", 1'b0, I_ADDIU, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        chk("wd2_end timeout4", to4, 1'b0);
        chk_regs("wd2_end", 1, 9, I_ADDIU, 32'h5555AAAA);

        // reset asserted mid-EXEC2 of a load aborts it without a retire
        do_reset("reset_ab");
        cyc("ab_fetch", 1'b0, I_LW, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        cyc("ab_exec1", 1'b0, D_BEEF, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort_async");
        @(posedge clk);
        #1;
        chk("abort_held state0", st0, 2'b00);
        chk("abort_held instr_count0", ic0, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cur = 2'b00;
        cyc("ab_refetch", 1'b0, I_ADDIU, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        chk_regs("ab_refetch", 0, 0, I_ADDIU, 0);
        cyc("ab_retire", 1'b0, I_ADDIU, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        chk_regs("ab_retire", 1, 0, I_ADDIU, 0);

        // random instruction stream against an instruction-level model
        do_reset("reset_rand");
        m_ic = 0; m_sc = 0; m_ins = 0; m_ld = 0;
        for (int n = 0; n < 150; n++) begin
            fw   = int'($urandom_range(0, 3));
            ew   = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 2));
            re   = 1'($urandom_range(0, 1));
            rr   = (kind == 1);
            rw   = (kind == 2);
            m_ins = $urandom;
            dat   = $urandom;
            for (int k = 0; k < fw; k++) cyc("rnd_fstall", 1'b1, $urandom, 1'b0, re, rr, rw, 2'b00, 1'b0);
            m_sc += 32'(fw);
            cyc("rnd_fetch", 1'b0, m_ins, 1'b0, re, rr, rw, 2'b01, 1'b0);
            if (rr || rw) begin
                for (int k = 0; k < ew; k++) cyc("rnd_estall", 1'b1, $urandom, 1'b0, re, rr, rw, 2'b01, 1'b0);
                m_sc += 32'(ew);
                cyc("rnd_exec1", 1'b0, dat, 1'b0, re, rr, rw, re ? 2'b10 : 2'b00, !re);
            end else begin
                cyc("rnd_exec1", 1'($urandom_range(0, 1)), dat, 1'b0, re, rr, rw, re ? 2'b10 : 2'b00, !re);
            end
            if (rr) m_ld = dat;
            if (re) cyc("rnd_exec2", 1'($urandom_range(0, 1)), $urandom, 1'b0, re, rr, rw, 2'b00, 1'b1);
            m_ic += 1;
            chk_regs($sformatf("rnd%0d", n), m_ic, m_sc, m_ins, m_ld);
            chk("rnd timeout4", to4, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_sequencer.md
# mips_sequencer

Multi-cycle state sequencer for the MIPS CPU core. It produces the 2-bit `state` consumed by the instruction decoder (FETCH/EXEC1/EXEC2/HALT) and advances it using the decoder's `Extra`, `Halt`, `MemRead` and `MemWrite` outputs and the Avalon `waitrequest`. It owns the instruction and load-data registers. It also produces a retire pulse for the program counter, instruction and stall counters, and a memory-wait watchdog that halts the core on a hung bus.

## Interface
- `COUNT_W`, 32: width of the retire and stall counters. Counters wrap modulo 2^COUNT_W.
- `MAX_WAIT`, 0: maximum consecutive `waitrequest` cycles tolerated. 0 disables the watchdog.
- `clk`  in  1  single core clock; all state is updated on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `waitrequest`  in  1  Avalon slave busy.
- `readdata`  in  32  Avalon read data.
- `halt`  in  1  decoder `Halt` (pc == 0).
- `extra`  in  1  decoder `Extra`: the instruction needs EXEC2.
- `mem_read`  in  1  decoder `MemRead`, valid in EXEC1.
- `mem_write`  in  1  decoder `MemWrite`, valid in EXEC1.
- `state`  out  2  00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALT.
- `instr`  out  32  instruction register.
- `load_data`  out  32  load-data register.
- `fetch_read`  out  1  instruction read request, = (state==FETCH && !halt).
- `retire`  out  1  single-cycle pulse; the instruction completes at this edge.
- `active`  out  1  = (state != HALT).
- `timeout`  out  1  sticky; watchdog fired.
- `instr_count`  out  COUNT_W  retired instructions.
- `stall_count`  out  COUNT_W  total `waitrequest` stall cycles.

## Operation
- Reset values (asynchronous, while `reset_n`=0):
  - `state`=FETCH; `instr`=0, `load_data`=0.
  - Counters=0; `timeout`=0; `retire`=0; `active`=1.
  - Internal wait counter `wcnt`=0.
- A memory phase is pending in:
  - FETCH with `halt`=0.
  - EXEC1 with `mem_read`||`mem_write`.
- FETCH:
  - `halt`=1 → HALT. No read is issued.
  - Otherwise, `waitrequest`=1 → stay in FETCH.
  - `waitrequest`=0 → `instr`<=`readdata`, go to EXEC1.
- EXEC1:
  - Memory phase pending and `waitrequest`=1 → stay in EXEC1.
  - Otherwise, on leaving EXEC1: if `mem_read`, `load_data`<=`readdata`.
  - Then `extra`=1 → EXEC2; else → FETCH with `retire`=1.
- EXEC2: unconditionally → FETCH with `retire`=1.
- HALT: absorbing. Only `reset_n` leaves it. No outputs change except `active`=0. Counters freeze.
- `retire` is a registered pulse, high for exactly the one cycle after the EXEC→FETCH edge.
  - `instr_count` increments on that same edge (+1, wraps to 0).
- `stall_count` increments by 1 on every edge where a memory phase is pending and `waitrequest`=1.
- Watchdog (MAX_WAIT>0):
  - `wcnt` increments on each stalled edge and clears on any non-stalled edge.
  - If a stalled edge occurs with `wcnt`==MAX_WAIT-1: go to HALT and set `timeout`=1 instead of staying.
  - MAX_WAIT=0: `wcnt` is held at 0 and `timeout` never asserts.
- Priorities:
  - FETCH with `halt`: `halt` beats `waitrequest`.
  - Watchdog expiry: `waitrequest`=0 on the deciding edge beats expiry, so no timeout.
- `instr` and `load_data` hold their value in all other cycles.

## Timing
- Zero-wait instructions:
  - Non-extra: 2 cycles (FETCH, EXEC1).
  - Extra (loads): 3 cycles (FETCH, EXEC1, EXEC2).
- Each `waitrequest` cycle adds exactly one cycle to the phase it occurs in.
- Outputs:
  - `state`, `instr`, `load_data`, `retire`, counters and `timeout` are registered.
  - `fetch_read` and `active` are combinational from registered state and `halt`.
- `instr` is valid from the first cycle of EXEC1 until the next FETCH completes.
- Asserting `reset_n`=0 mid-instruction aborts it immediately:
  - No retire and no count.
  - Execution restarts in FETCH on the first rising edge after `reset_n` rises.

## Test plan
- Reset, then 3 non-load instructions with `waitrequest`=0 and `readdata`=0x24020005:
  - `state` sequence 00,01,00,01,00,01.
  - `retire` pulses at cycles 2, 4, 6.
  - `instr_count`=3, `stall_count`=0, `instr`=0x24020005.
- Load instruction (`extra`=1, `mem_read`=1) with `waitrequest` high for 2 cycles in EXEC1, `readdata`=0xDEADBEEF:
  - `state` 00,01,01,01,10,00.
  - `load_data`=0xDEADBEEF.
  - `stall_count`=2, `instr_count`=1.
- `halt`=1 in FETCH while `waitrequest`=1:
  - Next state 11, `active`=0, `fetch_read`=0, `timeout`=0.
  - Counters frozen for 10 further cycles.
- MAX_WAIT=4, `waitrequest` stuck high in FETCH:
  - After 4 stalled edges, `state`=11 and `timeout`=1.
- MAX_WAIT=4, `waitrequest` deasserts exactly on the 4th edge:
  - `state`=01, `timeout`=0.
  - A later 3-cycle stall does not fire the watchdog, because `wcnt` cleared.
- `reset_n` pulsed low during EXEC2 of a load:
  - All outputs return to their reset values asynchronously, with `instr_count` unchanged from 0.
  - Execution resumes with FETCH.
